l5_cell: RTL
============

# l5_cell

Parametrised successor to the layered Lee-router cell. One instance sits at each grid site of the routing array. It holds a rotating stack of per-layer cell states and performs the wavefront operations: clear, write, expand, read. It adds three things: a per-cell traversal cost that delays wavefront arrival (weighted routing), a registered status output, and a synchronous reset.

## Interface
- NLAYERS, 8: depth of the per-cell layer shift register (≥2).
- COST_W, 3: width of the per-layer cost and countdown fields (1..4).
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; clears all layers, di, status_out, cost_out.
- cmd  in  3  000 CLEARX, 001 WRITE, 010 EXPAND, 011 READ, 100 WRITE_COST, 101 READ_COST, 110/111 NOP.
- ni, si, wi, ei  in  1  neighbour xo inputs.
- rsel, csel  in  1  row/column select; is_sel = rsel & csel.
- top_l, etch_enb, extend, ret2ue  in  1  same meaning as in the L4 array.
- pref_ud, pref_ew, pref_ns  in  1  expansion direction preferences; pref_ud also rotates layers.
- status_in  in  4  state written by WRITE.
- cost_in  in  COST_W  cost written by WRITE_COST.
- status_out  out  4  registered status.
- cost_out  out  COST_W  registered cost readback.
- xo  out  1  combinational "expanded" flag of layer 0.

## Operation
- Each layer word holds these fields: ret2ue flag, etched flag, 3-bit state (codes from L4_decs.v), pending flag, cost[COST_W], count[COST_W].
- Layer 0 is the current cell (cs).
- xo = (state is XE/XW/XN/XS/XU/XD and pending=0) or (extend and {etched,state}==TRACED).
- ui = layer 1 satisfies the xo predicate, and top_l=1.
- di: on pref_ud, di <= xo if top_l else 0.
- Layer update:
  - If pref_ud: layers[i] <= layers[i+1] and layers[NLAYERS-1] <= ns.
  - Else: layers[0] <= ns.
- CLEARX:
  - If the cell is directional (pending or not), or traced with extend=0: clear pending, count and ret2ue.
  - Then state becomes UNETCHABLE if ret2ue was set, else UNETCHED_EMPTY if not etched, else UNETCHED_BLOCKED.
  - cost is kept.
- WRITE, when is_sel: {etched,state} <= status_in, ret2ue <= ret2ue input, pending <= 0, count <= 0.
- WRITE_COST, when is_sel: cost <= cost_in.
- EXPAND, on a cell that is UNETCHED_EMPTY, or UNETCHED_BLOCKED with etch_enb:
  - The first winning source in priority order E, W, N, S, U, D is taken. Each source is gated by its pref (ei/wi need pref_ew; ni/si need pref_ns; ui/di need pref_ud).
  - {etched,state} <= {etch_enb, dir}.
  - If cost≠0: pending <= 1 and count <= cost.
  - Either way, status bit1 <= 0; if also is_sel, bit0 <= 0.
- EXPAND, on a pending cell: each EXPAND with the cell in layer 0 does the following.
  - If count==1: pending <= 0 and count <= 0.
  - Else: count <= count-1.
  - status bit1 <= 0 while pending, so the controller does not see a dead wavefront.
- EXPAND, any cell: if xo and is_sel, bit0 <= 0.
- Countdown holds on every non-EXPAND command.
- READ, when is_sel: status <= {etched,state}; otherwise 4'hF.
- READ_COST, when is_sel: cost_out <= cost; otherwise cost_out <= 0.
- NOP: state held, status 4'hF.
- Unselected WRITE, WRITE_COST and READ leave state unchanged and give status 4'hF.

## Timing
- Reset values:
  - All layers: UNETCHED_EMPTY with all flags, cost and count 0.
  - di=0, status_out=4'hF, cost_out=0.
  - xo is therefore 0 after reset.
- Reset mid-expansion discards pending counts immediately.
- status_out and cost_out have 1-cycle latency: the value reflects the command presented in the previous cycle.
- Wavefront arrival: a neighbour xo at EXPAND edge t makes this cell's xo rise after edge t+cost.
  - Cost 0 matches L4 behaviour exactly.
  - Cost c adds c further EXPAND cycles.
- Simultaneous arrivals resolve by the fixed priority; later arrivals are ignored once the cell is pending or directional.
- With pref_ud=1, pending layers rotate with their count frozen. Their countdown resumes only when they return to layer 0 under EXPAND.
- An undefined cmd cannot occur (8 codes defined).

## Configuration
- Macro L5_WEIGHTED_EN.
- Defined: cost, count and pending storage, the WRITE_COST and READ_COST commands, and delayed expansion are all compiled in.
- Undefined:
  - These fields are removed and every cell behaves as cost 0.
  - WRITE_COST and READ_COST act as NOP; cost_out is tied to 0.
  - Layer word shrinks to 5 bits.

## Test plan
- Reset with cmd=NOP:
  - status_out=4'hF, cost_out=0, xo=0.
  - READ selected, then status_out=UNETCHED_EMPTY next cycle.
- Cost 0, ei=1, pref_ew=1, EXPAND, etch_enb=0:
  - state becomes XE and xo=1 after the edge.
  - status_out bit1=0 the following cycle.
- WRITE_COST 3, then ni=1, pref_ns=1, EXPAND for 4 cycles:
  - xo stays 0 after edges 1–3 and rises after edge 4.
  - bit1=0 on every one of those status cycles.
- ei and ni both asserted, both prefs set: state becomes XE. CLEARX with the ret2ue flag set gives UNETCHABLE.
- Pending cell (cost 2, count 2): pref_ud for NLAYERS cycles, then EXPAND twice. xo rises only after the second EXPAND.
- Assert reset while count=2: the cell returns to UNETCHED_EMPTY with pending=0 and cost=0 on the next edge.

Source files
------------

// File: rtl/l5_cell.sv
// l5_cell: weighted layered Lee-router cell with a rotating per-layer state stack.
// Define L5_WEIGHTED_EN to compile in per-cell cost, countdown and the cost commands.
module l5_cell #(
    parameter int NLAYERS = 8,
    parameter int COST_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cmd,
    input  logic              ni,
    input  logic              si,
    input  logic              wi,
    input  logic              ei,
    input  logic              rsel,
    input  logic              csel,
    input  logic              top_l,
    input  logic              etch_enb,
    input  logic              extend,
    input  logic              ret2ue,
    input  logic              pref_ud,
    input  logic              pref_ew,
    input  logic              pref_ns,
    input  logic [3:0]        status_in,
    input  logic [COST_W-1:0] cost_in,
    output logic [3:0]        status_out,
    output logic [COST_W-1:0] cost_out,
    output logic              xo
);
    localparam logic [2:0] CLEARX = 3'd0, WRITE = 3'd1, EXPAND = 3'd2, READ = 3'd3;
    localparam logic [2:0] WRITE_COST = 3'd4, READ_COST = 3'd5;
    localparam logic [3:0] UNETCHED_EMPTY = 4'b0000, UNETCHED_BLOCKED = 4'b1000;
    localparam logic [3:0] UNETCHABLE = 4'b0111, TRACED = 4'b1111;
    typedef struct packed {
        logic              ret2ue;
        logic              etched;
        logic [2:0]        state;
`ifdef L5_WEIGHTED_EN
        logic              pending;
        logic [COST_W-1:0] cost;
        logic [COST_W-1:0] count;
`endif
    } layer_t;
    layer_t     r_layers [NLAYERS];
    layer_t     w_cs, w_ns;
    logic       r_di;
    logic [3:0] r_status, w_status, w_cst;
    logic [2:0] w_dir;
    logic       w_sel, w_ui, w_dirn, w_cand;
    // a directional cell still counting down its cost does not yet drive its neighbours
    function automatic logic f_xo(input layer_t l, input logic ext);
        logic p;
`ifdef L5_WEIGHTED_EN
        p = l.pending;
`else
        p = 1'b0;
`endif
        return (l.state inside {[3'd1:3'd6]} && !p) || (ext && {l.etched, l.state} == TRACED);
    endfunction
    assign w_cs   = r_layers[0];
    assign w_cst  = {w_cs.etched, w_cs.state};
    assign w_sel  = rsel & csel;
    assign xo     = f_xo(w_cs, extend);
    assign w_ui   = top_l & f_xo(r_layers[1], extend);
    assign w_dirn = w_cs.state inside {[3'd1:3'd6]};
    assign w_dir  = (pref_ew && ei) ? 3'd1 : (pref_ew && wi) ? 3'd2 :
                    (pref_ns && ni) ? 3'd3 : (pref_ns && si) ? 3'd4 :
                    (pref_ud && w_ui) ? 3'd5 : (pref_ud && r_di) ? 3'd6 : 3'd0;
    assign w_cand = (w_cst == UNETCHED_EMPTY || (w_cst == UNETCHED_BLOCKED && etch_enb)) && w_dir != 3'd0;
`ifdef L5_WEIGHTED_EN
    logic [COST_W-1:0] r_cost_out, w_cout;
    assign cost_out = r_cost_out;
`else
    logic w_unused;
    assign w_unused = ^cost_in;
    assign cost_out = '0;
`endif
    always_comb begin
        w_ns     = w_cs;
        w_status = 4'hF;
`ifdef L5_WEIGHTED_EN
        w_cout   = '0;
`endif
        case (cmd)
            CLEARX: if (w_dirn || (w_cst == TRACED && !extend)) begin
                {w_ns.etched, w_ns.state} = w_cs.ret2ue ? UNETCHABLE : w_cs.etched ? UNETCHED_BLOCKED : UNETCHED_EMPTY;
                w_ns.ret2ue = 1'b0;
`ifdef L5_WEIGHTED_EN
                w_ns.pending = 1'b0;
                w_ns.count   = '0;
`endif
            end
            WRITE: if (w_sel) begin
                {w_ns.etched, w_ns.state} = status_in;
                w_ns.ret2ue = ret2ue;
`ifdef L5_WEIGHTED_EN
                w_ns.pending = 1'b0;
                w_ns.count   = '0;
`endif
            end
            EXPAND: begin
                if (w_cand) begin
                    {w_ns.etched, w_ns.state} = {etch_enb, w_dir};
`ifdef L5_WEIGHTED_EN
                    w_ns.pending = |w_cs.cost;
                    w_ns.count   = w_cs.cost;
`endif
                    w_status[1] = 1'b0;
                    w_status[0] = ~w_sel;
                end
`ifdef L5_WEIGHTED_EN
                else if (w_cs.pending) begin
                    w_status[1] = 1'b0;
                    if (!pref_ud) begin
                        w_ns.pending = w_cs.count != COST_W'(1);
                        w_ns.count   = w_cs.count - COST_W'(1);
                    end
                end
`endif
                if (xo && w_sel) w_status[0] = 1'b0;
            end
            READ: w_status = w_sel ? w_cst : 4'hF;
`ifdef L5_WEIGHTED_EN
            WRITE_COST: if (w_sel) w_ns.cost = cost_in;
            READ_COST: w_cout = w_sel ? w_cs.cost : '0;
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NLAYERS; i++) r_layers[i] <= '0;
            r_di     <= 1'b0;
            r_status <= 4'hF;
`ifdef L5_WEIGHTED_EN
            r_cost_out <= '0;
`endif
        end else begin
            if (pref_ud) begin
                for (int i = 0; i < NLAYERS - 1; i++) r_layers[i] <= r_layers[i+1];
                r_layers[NLAYERS-1] <= w_ns;
                r_di <= top_l & xo;
            end else begin
                r_layers[0] <= w_ns;
            end
            r_status <= w_status;
`ifdef L5_WEIGHTED_EN
            r_cost_out <= w_cout;
`endif
        end
    end
    assign status_out = r_status;
endmodule
